// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the in-order pipeline: tracks in-flight writers
// after ID, selects forwarding sources, inserts load-use bubbles and handles redirect/freeze.
module pipe_hazard_ctrl #(
    parameter  int STAGES     = 3,
    parameter  int LOAD_READY = 2,
    parameter  int IDX_W      = 5,
    parameter  int CNT_W      = 16,
    localparam int FW_W       = $clog2(STAGES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid_i,
    input  logic [IDX_W-1:0] rs1_idx_d_i,
    input  logic [IDX_W-1:0] rs2_idx_d_i,
    input  logic             rs1_used_d_i,
    input  logic             rs2_used_d_i,
    input  logic [IDX_W-1:0] rd_idx_d_i,
    input  logic             reg_write_en_d_i,
    input  logic             is_load_d_i,
    input  logic             taken_d_i,
    input  logic             mem_wait_i,
    output logic             enable_o,
    output logic             bubble_e_o,
    output logic             flush_d_o,
    output logic [FW_W-1:0]  rs1_fwd_o,
    output logic [FW_W-1:0]  rs2_fwd_o,
    output logic             rs1_depended_o,
    output logic             rs2_depended_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    // Scoreboard: entry k describes the instruction leaving stage k (1 = EXE).
    logic [STAGES:1]            sb_valid_r;
    logic [STAGES:1]            sb_wen_r;
    logic [STAGES:1]            sb_load_r;
    logic [STAGES:1][IDX_W-1:0] sb_rd_r;
    logic [CNT_W-1:0]           stall_cnt_r;

    logic                       rs1_req_s;
    logic                       rs2_req_s;
    logic [FW_W:0]              rs1_res_s;
    logic [FW_W:0]              rs2_res_s;
    logic                       hazard_s;
    logic                       enable_s;
    logic                       bubble_s;
    logic                       flush_s;

    // Returns {load_use_hazard, fwd_select}; the descending scan leaves the youngest writer.
    function automatic logic [FW_W:0] resolve_src(
        input logic                       req,
        input logic [IDX_W-1:0]           src,
        input logic [STAGES:1]            valid,
        input logic [STAGES:1]            wen,
        input logic [STAGES:1]            load,
        input logic [STAGES:1][IDX_W-1:0] rd
    );
        logic [FW_W-1:0] fwd;
        logic            hz;
        fwd = {FW_W{1'b0}};
        hz  = 1'b0;
        for (int k = STAGES; k >= 1; k--) begin
            if (req && valid[k] && wen[k] && (rd[k] == src)) begin
                fwd = FW_W'(k);
                hz  = load[k] && (k < LOAD_READY);
            end
        end
        return {hz, fwd};
    endfunction

    // Source lookup: x0 and unused/invalid sources never match.
    always_comb begin
        rs1_req_s = id_valid_i && rs1_used_d_i && (rs1_idx_d_i != {IDX_W{1'b0}});
        rs2_req_s = id_valid_i && rs2_used_d_i && (rs2_idx_d_i != {IDX_W{1'b0}});
        rs1_res_s = resolve_src(rs1_req_s, rs1_idx_d_i, sb_valid_r, sb_wen_r, sb_load_r, sb_rd_r);
        rs2_res_s = resolve_src(rs2_req_s, rs2_idx_d_i, sb_valid_r, sb_wen_r, sb_load_r, sb_rd_r);
        hazard_s  = rs1_res_s[FW_W] | rs2_res_s[FW_W];
    end

    // Pipe control priority: memory freeze, then load-use stall, then normal advance.
    always_comb begin
        enable_s = 1'b1;
        bubble_s = 1'b0;
        flush_s  = 1'b0;
        if (mem_wait_i) begin
            enable_s = 1'b0;
        end else if (hazard_s) begin
            enable_s = 1'b0;
            bubble_s = 1'b1;
        end else begin
            flush_s  = taken_d_i;
        end
    end

    // Scoreboard shift; a bubble enters EXE as an invalid entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            sb_valid_r <= {STAGES{1'b0}};
            sb_wen_r   <= {STAGES{1'b0}};
            sb_load_r  <= {STAGES{1'b0}};
            sb_rd_r    <= '0;
        end else if (!mem_wait_i) begin
            for (int k = STAGES; k >= 2; k--) begin
                sb_valid_r[k] <= sb_valid_r[k-1];
                sb_wen_r[k]   <= sb_wen_r[k-1];
                sb_load_r[k]  <= sb_load_r[k-1];
                sb_rd_r[k]    <= sb_rd_r[k-1];
            end
            sb_valid_r[1] <= id_valid_i & ~bubble_s;
            sb_wen_r[1]   <= reg_write_en_d_i;
            sb_load_r[1]  <= is_load_d_i;
            sb_rd_r[1]    <= rd_idx_d_i;
        end else begin
            sb_valid_r <= sb_valid_r;
        end
    end

    // Saturating load-use stall counter; frozen cycles are not counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (!mem_wait_i && hazard_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign enable_o       = enable_s;
    assign bubble_e_o     = bubble_s;
    assign flush_d_o      = flush_s;
    assign rs1_fwd_o      = rs1_res_s[FW_W-1:0];
    assign rs2_fwd_o      = rs2_res_s[FW_W-1:0];
    assign rs1_depended_o = (rs1_res_s[FW_W-1:0] != {FW_W{1'b0}});
    assign rs2_depended_o = (rs2_res_s[FW_W-1:0] != {FW_W{1'b0}});
    assign stall_cnt_o    = stall_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model,
// run on a default instance (3 stages) and a deep instance (4 stages, load ready at 3, 2-bit counter).
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, id_valid, rs1_used, rs2_used, reg_write_en, is_load, taken, mem_wait;
    logic [4:0] rs1_idx, rs2_idx, rd_idx;

    logic        a_en, a_bub, a_fl, a_d1, a_d2;
    logic [1:0]  a_f1, a_f2;
    logic [15:0] a_cnt;
    logic        b_en, b_bub, b_fl, b_d1, b_d2;
    logic [2:0]  b_f1, b_f2;
    logic [1:0]  b_cnt;

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl dut_a (
        .clk(clk), .reset(reset), .id_valid_i(id_valid),
        .rs1_idx_d_i(rs1_idx), .rs2_idx_d_i(rs2_idx),
        .rs1_used_d_i(rs1_used), .rs2_used_d_i(rs2_used),
        .rd_idx_d_i(rd_idx), .reg_write_en_d_i(reg_write_en), .is_load_d_i(is_load),
        .taken_d_i(taken), .mem_wait_i(mem_wait),
        .enable_o(a_en), .bubble_e_o(a_bub), .flush_d_o(a_fl),
        .rs1_fwd_o(a_f1), .rs2_fwd_o(a_f2),
        .rs1_depended_o(a_d1), .rs2_depended_o(a_d2), .stall_cnt_o(a_cnt)
    );

    pipe_hazard_ctrl #(.STAGES(4), .LOAD_READY(3), .IDX_W(5), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .id_valid_i(id_valid),
        .rs1_idx_d_i(rs1_idx), .rs2_idx_d_i(rs2_idx),
        .rs1_used_d_i(rs1_used), .rs2_used_d_i(rs2_used),
        .rd_idx_d_i(rd_idx), .reg_write_en_d_i(reg_write_en), .is_load_d_i(is_load),
        .taken_d_i(taken), .mem_wait_i(mem_wait),
        .enable_o(b_en), .bubble_e_o(b_bub), .flush_d_o(b_fl),
        .rs1_fwd_o(b_f1), .rs2_fwd_o(b_f2),
        .rs1_depended_o(b_d1), .rs2_depended_o(b_d2), .stall_cnt_o(b_cnt)
    );

    // In-flight instruction as seen by the model; queue index 0 is the youngest (EXE).
    typedef struct {
        bit v;
        int rd;
        bit wen;
        bit ld;
    } ent_t;

    ent_t qa[$];
    ent_t qb[$];
    int   cnt_a, cnt_b;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        id_valid = 1'b0; rs1_idx = 5'd0; rs2_idx = 5'd0; rs1_used = 1'b0; rs2_used = 1'b0;
        rd_idx = 5'd0; reg_write_en = 1'b0; is_load = 1'b0; taken = 1'b0; mem_wait = 1'b0;
    endtask

    task automatic do_reset();
        clear_in();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic set_writer(input int rd, input bit ld);
        clear_in();
        id_valid = 1'b1; rd_idx = 5'(rd); reg_write_en = 1'b1; is_load = ld;
    endtask

    task automatic set_reader(input int s1);
        clear_in();
        id_valid = 1'b1; rs1_idx = 5'(s1); rs1_used = 1'b1;
    endtask

    function automatic int find_writer(input ent_t q[$], input int s);
        for (int k = 0; k < q.size(); k++)
            if (q[k].v && q[k].wen && q[k].rd == s) return k + 1;
        return 0;
    endfunction

    task automatic test_reset();
        clear_in();
        reset = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checks++; if (a_en !== 1'b1) begin errors++; $display("FAIL reset_en got %0b want 1", a_en); end
        checks++; if (a_bub !== 1'b0 || a_fl !== 1'b0) begin errors++; $display("FAIL reset_bub_fl got %0b%0b want 00", a_bub, a_fl); end
        checks++; if (a_f1 !== 2'd0 || a_f2 !== 2'd0 || a_d1 !== 1'b0 || a_d2 !== 1'b0) begin errors++; $display("FAIL reset_fwd got %0d/%0d want 0/0", a_f1, a_f2); end
        checks++; if (a_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", a_cnt); end
        checks++; if (b_cnt !== 2'd0 || b_en !== 1'b1) begin errors++; $display("FAIL reset_b got cnt %0d en %0b want 0 1", b_cnt, b_en); end
        tick();
        reset = 1'b0;
        set_reader(5);
        @(negedge clk);
        checks++; if (a_f1 !== 2'd0 || a_d1 !== 1'b0) begin errors++; $display("FAIL reset_x5 got %0d want 0", a_f1); end
        tick();
    endtask

    task automatic test_alu_chain();
        do_reset();
        set_writer(5, 1'b0);
        tick();
        set_reader(5);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++; if (a_f1 !== 2'(k % 4) || a_d1 !== (k < 4)) begin errors++; $display("FAIL alu_fwd_%0d got %0d want %0d", k, a_f1, k % 4); end
            checks++; if (a_en !== 1'b1 || a_bub !== 1'b0) begin errors++; $display("FAIL alu_en_%0d got %0b want 1", k, a_en); end
            tick();
        end
    endtask

    task automatic test_youngest();
        do_reset();
        set_writer(7, 1'b0);
        tick();
        tick();
        clear_in();
        id_valid = 1'b1; rs1_idx = 5'd7; rs2_idx = 5'd7; rs1_used = 1'b1; rs2_used = 1'b1;
        @(negedge clk);
        checks++; if (a_f1 !== 2'd1 || a_f2 !== 2'd1 || a_d2 !== 1'b1) begin errors++; $display("FAIL youngest got %0d/%0d want 1/1", a_f1, a_f2); end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        set_writer(6, 1'b1);
        tick();
        set_reader(6);
        @(negedge clk);
        checks++; if (a_en !== 1'b0 || a_bub !== 1'b1) begin errors++; $display("FAIL lu_stall got en %0b bub %0b want 0 1", a_en, a_bub); end
        checks++; if (b_en !== 1'b0 || b_bub !== 1'b1) begin errors++; $display("FAIL lu_b_stall1 got en %0b bub %0b want 0 1", b_en, b_bub); end
        tick();
        @(negedge clk);
        checks++; if (a_en !== 1'b1 || a_bub !== 1'b0 || a_f1 !== 2'd2) begin errors++; $display("FAIL lu_after got en %0b fwd %0d want 1 2", a_en, a_f1); end
        checks++; if (a_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt got %0d want 1", a_cnt); end
        checks++; if (b_en !== 1'b0 || b_bub !== 1'b1 || b_cnt !== 2'd1) begin errors++; $display("FAIL lu_b_stall2 got en %0b cnt %0d want 0 1", b_en, b_cnt); end
        tick();
        @(negedge clk);
        checks++; if (b_en !== 1'b1 || b_f1 !== 3'd3 || b_cnt !== 2'd2) begin errors++; $display("FAIL lu_b_after got en %0b fwd %0d cnt %0d want 1 3 2", b_en, b_f1, b_cnt); end
        checks++; if (a_f1 !== 2'd3) begin errors++; $display("FAIL lu_a_wb got %0d want 3", a_f1); end
        tick();
    endtask

    task automatic test_x0();
        do_reset();
        set_writer(0, 1'b1);
        tick();
        clear_in();
        id_valid = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
        @(negedge clk);
        checks++; if (a_f1 !== 2'd0 || a_f2 !== 2'd0 || a_d1 !== 1'b0) begin errors++; $display("FAIL x0_fwd got %0d/%0d want 0/0", a_f1, a_f2); end
        checks++; if (a_en !== 1'b1 || a_bub !== 1'b0) begin errors++; $display("FAIL x0_stall got en %0b want 1", a_en); end
        tick();
    endtask

    task automatic test_freeze();
        do_reset();
        set_writer(6, 1'b1);
        tick();
        set_reader(6);
        mem_wait = 1'b1;
        taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (a_en !== 1'b0 || a_bub !== 1'b0 || a_fl !== 1'b0) begin errors++; $display("FAIL frz_ctl_%0d got %0b%0b%0b want 000", i, a_en, a_bub, a_fl); end
            checks++; if (a_cnt !== 16'd0 || b_cnt !== 2'd0) begin errors++; $display("FAIL frz_cnt_%0d got %0d want 0", i, a_cnt); end
            tick();
        end
        mem_wait = 1'b0;
        taken = 1'b0;
        @(negedge clk);
        checks++; if (a_en !== 1'b0 || a_bub !== 1'b1 || a_cnt !== 16'd0) begin errors++; $display("FAIL frz_release got en %0b bub %0b want 0 1", a_en, a_bub); end
        tick();
        @(negedge clk);
        checks++; if (a_en !== 1'b1 || a_f1 !== 2'd2 || a_cnt !== 16'd1) begin errors++; $display("FAIL frz_after got fwd %0d cnt %0d want 2 1", a_f1, a_cnt); end
        tick();
    endtask

    task automatic test_redirect();
        do_reset();
        clear_in();
        id_valid = 1'b1; taken = 1'b1;
        @(negedge clk);
        checks++; if (a_fl !== 1'b1 || a_en !== 1'b1) begin errors++; $display("FAIL redir_flush got %0b want 1", a_fl); end
        tick();
        set_writer(6, 1'b1);
        @(negedge clk);
        checks++; if (a_fl !== 1'b0) begin errors++; $display("FAIL redir_clear got %0b want 0", a_fl); end
        tick();
        set_reader(6);
        taken = 1'b1;
        @(negedge clk);
        checks++; if (a_fl !== 1'b0 || a_en !== 1'b0) begin errors++; $display("FAIL redir_stall got fl %0b en %0b want 0 0", a_fl, a_en); end
        tick();
        @(negedge clk);
        checks++; if (a_fl !== 1'b1 || a_en !== 1'b1 || a_f1 !== 2'd2) begin errors++; $display("FAIL redir_after got fl %0b fwd %0d want 1 2", a_fl, a_f1); end
        tick();
    endtask

    task automatic test_random(input int n);
        int  f1, f2, s1, s2;
        bit  h1, h2, hz, r1, r2;
        bit  e_en, e_bub, e_fl;
        do_reset();
        qa.delete(); qb.delete(); cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < n; i++) begin
            reset        = ($urandom_range(0, 299) == 0);
            id_valid     = ($urandom_range(0, 7) != 0);
            rs1_idx      = 5'($urandom_range(0, 7));
            rs2_idx      = 5'($urandom_range(0, 7));
            rs1_used     = 1'($urandom_range(0, 1));
            rs2_used     = 1'($urandom_range(0, 1));
            rd_idx       = 5'($urandom_range(0, 7));
            reg_write_en = 1'($urandom_range(0, 1));
            is_load      = ($urandom_range(0, 2) == 0);
            taken        = ($urandom_range(0, 3) == 0);
            mem_wait     = ($urandom_range(0, 7) == 0);
            s1 = int'(rs1_idx); s2 = int'(rs2_idx);
            r1 = id_valid && rs1_used && s1 != 0;
            r2 = id_valid && rs2_used && s2 != 0;
            @(negedge clk);
            // default instance: load data usable from stage 2
            f1 = r1 ? find_writer(qa, s1) : 0;
            f2 = r2 ? find_writer(qa, s2) : 0;
            h1 = (f1 != 0) && qa[f1-1].ld && (f1 < 2);
            h2 = (f2 != 0) && qa[f2-1].ld && (f2 < 2);
            hz = h1 || h2;
            e_en = !mem_wait && !hz; e_bub = !mem_wait && hz; e_fl = e_en && taken;
            checks++; if ({a_en, a_bub, a_fl} !== {e_en, e_bub, e_fl}) begin errors++; $display("FAIL rnd_a_ctl cyc %0d got %0b%0b%0b want %0b%0b%0b", i, a_en, a_bub, a_fl, e_en, e_bub, e_fl); end
            checks++; if (a_cnt !== 16'(cnt_a)) begin errors++; $display("FAIL rnd_a_cnt cyc %0d got %0d want %0d", i, a_cnt, cnt_a); end
            if (!h1) begin checks++; if (a_f1 !== 2'(f1) || a_d1 !== (f1 != 0)) begin errors++; $display("FAIL rnd_a_f1 cyc %0d got %0d want %0d", i, a_f1, f1); end end
            if (!h2) begin checks++; if (a_f2 !== 2'(f2) || a_d2 !== (f2 != 0)) begin errors++; $display("FAIL rnd_a_f2 cyc %0d got %0d want %0d", i, a_f2, f2); end end
            if (reset) begin qa.delete(); cnt_a = 0; end
            else if (!mem_wait) begin
                qa.push_front('{v: id_valid && !e_bub, rd: int'(rd_idx), wen: reg_write_en, ld: is_load});
                if (qa.size() > 3) void'(qa.pop_back());
                if (hz && cnt_a < 65535) cnt_a++;
            end
            // deep instance: load data usable from stage 3, 2-bit counter
            f1 = r1 ? find_writer(qb, s1) : 0;
            f2 = r2 ? find_writer(qb, s2) : 0;
            h1 = (f1 != 0) && qb[f1-1].ld && (f1 < 3);
            h2 = (f2 != 0) && qb[f2-1].ld && (f2 < 3);
            hz = h1 || h2;
            e_en = !mem_wait && !hz; e_bub = !mem_wait && hz; e_fl = e_en && taken;
            checks++; if ({b_en, b_bub, b_fl} !== {e_en, e_bub, e_fl}) begin errors++; $display("FAIL rnd_b_ctl cyc %0d got %0b%0b%0b want %0b%0b%0b", i, b_en, b_bub, b_fl, e_en, e_bub, e_fl); end
            checks++; if (b_cnt !== 2'(cnt_b)) begin errors++; $display("FAIL rnd_b_cnt cyc %0d got %0d want %0d", i, b_cnt, cnt_b); end
            if (!h1) begin checks++; if (b_f1 !== 3'(f1) || b_d1 !== (f1 != 0)) begin errors++; $display("FAIL rnd_b_f1 cyc %0d got %0d want %0d", i, b_f1, f1); end end
            if (!h2) begin checks++; if (b_f2 !== 3'(f2) || b_d2 !== (f2 != 0)) begin errors++; $display("FAIL rnd_b_f2 cyc %0d got %0d want %0d", i, b_f2, f2); end end
            if (reset) begin qb.delete(); cnt_b = 0; end
            else if (!mem_wait) begin
                qb.push_front('{v: id_valid && !e_bub, rd: int'(rd_idx), wen: reg_write_en, ld: is_load});
                if (qb.size() > 4) void'(qb.pop_back());
                if (hz && cnt_b < 3) cnt_b++;
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        clear_in();
        reset = 1'b1;
        tick();
        test_reset();
        test_alu_chain();
        test_youngest();
        test_load_use();
        test_x0();
        test_freeze();
        test_redirect();
        test_random(3000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
